move_rewind_engine: RTL

//   Records every applied cube move (face, quarter-turn count) in a circular LIFO.
//   On request it reads moves back and emits each one's inverse to the move engine

---
 rtl/cube_move_pkg.sv | 35 +++
 rtl/move_rewind_engine_if.sv | 46 ++++
 rtl/move_history_ram.sv | 24 ++
 rtl/move_rewind_engine.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cube_move_pkg.sv
// Shared cube move definitions: face codes, quarter-turn codes,
// the packed move record and the inverse-rotation helper.
package cube_move_pkg;

  localparam int FACE_W = 3;
  localparam int ROT_W  = 2;
  localparam int DEPTH_DEF = 64;

  localparam logic [FACE_W-1:0] FACE_U = 3'd0;
  localparam logic [FACE_W-1:0] FACE_R = 3'd1;
  localparam logic [FACE_W-1:0] FACE_F = 3'd2;
  localparam logic [FACE_W-1:0] FACE_D = 3'd3;
  localparam logic [FACE_W-1:0] FACE_L = 3'd4;
  localparam logic [FACE_W-1:0] FACE_B = 3'd5;

  localparam logic [ROT_W-1:0] ROT_NONE = 2'd0;
  localparam logic [ROT_W-1:0] ROT_CW   = 2'd1;
  localparam logic [ROT_W-1:0] ROT_DBL  = 2'd2;
  localparam logic [ROT_W-1:0] ROT_CCW  = 2'd3;

  typedef struct packed {
    logic [FACE_W-1:0] face;
    logic [ROT_W-1:0]  rot;
  } move_t;

  // (4 - rot) mod 4 is plain two's-complement negation
  function automatic logic [ROT_W-1:0] inv_rot(
    input logic [ROT_W-1:0] r
  );
    logic [ROT_W-1:0] z;
    z = '0;
    return z - r;
  endfunction

endpackage

// File: rtl/move_rewind_engine_if.sv
// Record / request / inverse-move bus of move_rewind_engine.
// master = the engine, slave = driver and move engine side.
interface move_rewind_engine_if #(
  parameter int DEPTH  = 64,
  parameter int FACE_W = 3,
  parameter int ROT_W  = 2
);
  localparam int DW = $clog2(DEPTH) + 1;

  logic              rec_valid;
  logic [FACE_W-1:0] rec_face;
  logic [ROT_W-1:0]  rec_rot;
  logic              undo_req;
  logic              rewind_req;
  logic              abort;
  logic              clear;
  logic              mv_valid;
  logic [FACE_W-1:0] mv_face;
  logic [ROT_W-1:0]  mv_rot;
  logic              mv_ready;
  logic [DW-1:0]     depth;
  logic              empty;
  logic              busy;
  logic              overflow;
  logic              rec_drop;
  logic              done;

  modport master (
    input  rec_valid, rec_face, rec_rot,
    input  undo_req, rewind_req, abort, clear,
    input  mv_ready,
    output mv_valid, mv_face, mv_rot,
    output depth, empty, busy,
    output overflow, rec_drop, done
  );

  modport slave (
    output rec_valid, rec_face, rec_rot,
    output undo_req, rewind_req, abort, clear,
    output mv_ready,
    input  mv_valid, mv_face, mv_rot,
    input  depth, empty, busy,
    input  overflow, rec_drop, done
  );

endinterface

// File: rtl/move_history_ram.sv
// Move history storage: one write port, one registered read port.
// Reads and writes never target the same cycle in normal use.
module move_history_ram #(
  parameter int DEPTH = 64,
  parameter int W     = 5,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic [AW-1:0] ra,
  output logic [W-1:0]  rd
);

  logic [W-1:0] mem [DEPTH];

  // write on request, read the addressed entry every cycle
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    rd <= mem[ra];
  end

endmodule

// File: rtl/move_rewind_engine.sv
// Circular LIFO of applied cube moves; replays inverses for undo/rewind.
// Optional RECORD_MERGE_EN folds same-face moves into the top entry.
module move_rewind_engine
  import cube_move_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int FACE_W = 3,
  parameter int ROT_W  = 2
) (
  input logic clk,
  input logic rst,
  move_rewind_engine_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;
  localparam int W  = FACE_W + ROT_W;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EMIT
  } state_t;

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] depth_q;
  logic          rewind_q;
  logic          mv_valid_q;
  logic          overflow_q;
  logic          rec_drop_q;
  logic          done_q;

  logic          we;
  logic [AW-1:0] wa;
  logic [W-1:0]  wd;
  logic [W-1:0]  rd_data;

  logic req;
  logic rec_ok;
  logic full;

  assign req    = bus.undo_req | bus.rewind_req;
  assign rec_ok = bus.rec_valid && (bus.rec_rot != '0);
  assign full   = (depth_q == DW'(DEPTH));

`ifdef RECORD_MERGE_EN
  // mirror of the top entry; only trusted right after a record
  logic              top_vld;
  logic [FACE_W-1:0] top_face;
  logic [ROT_W-1:0]  top_rot;
  logic              merge;
  logic [ROT_W-1:0]  sum;

  assign merge = top_vld && (depth_q != '0)
              && (bus.rec_face == top_face);
  assign sum   = top_rot + bus.rec_rot;
`endif

  // history write port driven by the IDLE record path
  always_comb begin
    we = 1'b0;
    wa = wr_ptr;
    wd = {bus.rec_face, bus.rec_rot};
    if (state == IDLE && !bus.clear && !req && rec_ok) begin
`ifdef RECORD_MERGE_EN
      if (merge) begin
        we = (sum != '0);
        wa = wr_ptr - AW'(1);
        wd = {bus.rec_face, sum};
      end else begin
        we = 1'b1;
      end
`else
      we = 1'b1;
`endif
    end
  end

  move_history_ram #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_ram (
    .clk (clk),
    .we  (we),
    .wa  (wa),
    .wd  (wd),
    .ra  (rd_addr),
    .rd  (rd_data)
  );

  // control FSM, pointers, depth and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_addr    <= '0;
      depth_q    <= '0;
      rewind_q   <= 1'b0;
      mv_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      rec_drop_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef RECORD_MERGE_EN
      top_vld    <= 1'b0;
      top_face   <= '0;
      top_rot    <= '0;
`endif
    end else begin
      rec_drop_q <= 1'b0;
      done_q     <= 1'b0;
      if (bus.clear) begin
        state      <= IDLE;
        wr_ptr     <= '0;
        depth_q    <= '0;
        overflow_q <= 1'b0;
        mv_valid_q <= 1'b0;
`ifdef RECORD_MERGE_EN
        top_vld    <= 1'b0;
`endif
      end else begin
        unique case (state)
          IDLE: begin
            if (req) begin
              rec_drop_q <= bus.rec_valid;
              if (depth_q != '0) begin
                rd_addr  <= wr_ptr - AW'(1);
                rewind_q <= bus.rewind_req;
                state    <= READ;
`ifdef RECORD_MERGE_EN
                top_vld  <= 1'b0;
`endif
              end else begin
                done_q <= 1'b1;
              end
            end else if (rec_ok) begin
`ifdef RECORD_MERGE_EN
              if (merge) begin
                if (sum == '0) begin
                  wr_ptr  <= wr_ptr - AW'(1);
                  depth_q <= depth_q - DW'(1);
                  top_vld <= 1'b0;
                end else begin
                  top_rot <= sum;
                end
              end else
`endif
              begin
                wr_ptr <= wr_ptr + AW'(1);
                if (full) overflow_q <= 1'b1;
                else depth_q <= depth_q + DW'(1);
`ifdef RECORD_MERGE_EN
                top_vld  <= 1'b1;
                top_face <= bus.rec_face;
                top_rot  <= bus.rec_rot;
`endif
              end
            end
          end
          READ: begin
            rec_drop_q <= bus.rec_valid;
            if (bus.abort) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end else begin
              state      <= EMIT;
              mv_valid_q <= 1'b1;
            end
          end
          EMIT: begin
            rec_drop_q <= bus.rec_valid;
            if (bus.mv_ready) begin
              wr_ptr     <= wr_ptr - AW'(1);
              depth_q    <= depth_q - DW'(1);
              mv_valid_q <= 1'b0;
              if (rewind_q && depth_q != DW'(1)
                  && !bus.abort) begin
                rd_addr <= rd_addr - AW'(1);
                state   <= READ;
              end else begin
                state  <= IDLE;
                done_q <= 1'b1;
              end
            end else if (bus.abort) begin
              state      <= IDLE;
              mv_valid_q <= 1'b0;
              done_q     <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // read data is held steady during EMIT since no writes occur
  assign bus.mv_valid = mv_valid_q;
  assign bus.mv_face  = mv_valid_q ? rd_data[W-1:ROT_W] : '0;
  assign bus.mv_rot   = mv_valid_q ? inv_rot(rd_data[ROT_W-1:0]) : '0;
  assign bus.depth    = depth_q;
  assign bus.empty    = (depth_q == '0);
  assign bus.busy     = (state != IDLE);
  assign bus.overflow = overflow_q;
  assign bus.rec_drop = rec_drop_q;
  assign bus.done     = done_q;

endmodule
